// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : instruction buffer payload {instr, pc}
//   fetch_state_e : fetch control state (HALT only reachable with FETCH_MISALIGN_CHECK_EN)
//   INSTR_BYTES   : PC increment per fetched word
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush; flush takes priority over both.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push_i / data_i    write request and payload (ignored when full unless popping)
//   pop_i              read request (ignored when empty)
//   flush_i            discard all entries this cycle
//   data_o             head entry (meaningful only when !empty_o)
//   count_o            number of stored entries
//   full_o / empty_o   occupancy flags
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rptr_q];
    assign do_pop_c  = pop_i && !empty_o;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push_c = push_i && (!full_o || do_pop_c);

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push_c) wptr_d = ptr_inc(wptr_q);
            if (do_pop_c)  rptr_d = ptr_inc(rptr_q);
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are qualified by empty_o.
    always_ff @(posedge clk) begin
        if (do_push_c && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words and hands {instr, pc, pc+4}
// to decode over a valid/ready handshake. Redirects flush the buffer and
// mark every in-flight response as stale.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a redirect to a target
// that is not word aligned raises sticky misaligned_o and halts fetch.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o  fetch request and word address
//   imem_gnt_i                memory accepts the request
//   imem_rvalid_i / _rdata_i  in-order read response
//   redirect_i / _pc_i        taken branch/jump and its target
//   id_valid_o / id_ready_i   decode handshake
//   instr_o, pc_o, pc_plus4_o head entry presented to decode
//   misaligned_o              misaligned redirect flag (0 unless macro defined)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misaligned_o
);

    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    fetch_state_e      state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [OCNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0]       tag_pc_c;
    logic [OCNT_W-1:0] outstanding_c;
    logic              tag_full_c;
    logic              tag_empty_c;

    fetch_entry_t      fifo_wdata_c;
    fetch_entry_t      head_c;
    logic [FCNT_W-1:0] fifo_count_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              fifo_flush_c;

    logic              req_c;
    logic              issue_c;
    logic              rsp_c;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
`else
    logic unused_pc_lsb_c;
    assign unused_pc_lsb_c = ^redirect_pc_i[1:0];
`endif

    // Issue only when every in-flight response is guaranteed a buffer slot.
    assign req_c = !rst && (state_q == RUN) && !redirect_i && !tag_full_c &&
                   ((32'(outstanding_c) + 32'(fifo_count_c)) < 32'(FIFO_DEPTH));
    assign issue_c = req_c && imem_gnt_i;
    assign rsp_c   = imem_rvalid_i && !tag_empty_c;

    assign imem_req_o  = req_c;
    assign imem_addr_o = fetch_pc_q;

    // PC tags of issued requests; its occupancy is the outstanding count.
    // Never flushed: stale responses still have to retire their tag.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue_c),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_c),
        .flush_i (1'b0),
        .data_o  (tag_pc_c),
        .count_o (outstanding_c),
        .full_o  (tag_full_c),
        .empty_o (tag_empty_c)
    );

    assign fifo_wdata_c = '{instr: imem_rdata_i, pc: tag_pc_c};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_c),
        .data_i  (fifo_wdata_c),
        .pop_i   (fifo_pop_c),
        .flush_i (fifo_flush_c),
        .data_o  (head_c),
        .count_o (fifo_count_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c)
    );

    // Next-state: redirect overrides issue, response buffering and decode pop.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_push_c  = 1'b0;
        fifo_pop_c   = 1'b0;
        fifo_flush_c = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif
        if (redirect_i) begin
            fifo_flush_c = 1'b1;
            fetch_pc_d   = {redirect_pc_i[31:2], 2'b00};
            // Everything still in flight after this cycle is wrong-path;
            // earlier stale responses are already part of that set.
            drop_cnt_d   = outstanding_c - OCNT_W'(rsp_c);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc_i[1:0] != 2'b00) begin
                state_d      = HALT;
                misaligned_d = 1'b1;
            end
`endif
        end else begin
            if (issue_c) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
            if (rsp_c) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - OCNT_W'(1);
                end else if ((state_q == RUN) && (!fifo_full_c || fifo_pop_c)) begin
                    fifo_push_c = 1'b1;
                end
            end
            fifo_pop_c = id_valid_o && id_ready_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            drop_cnt_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // Decode view of the head entry, zeroed while the buffer is empty.
    assign id_valid_o = !fifo_empty_c;
    assign instr_o    = id_valid_o ? head_c.instr : '0;
    assign pc_o       = id_valid_o ? head_c.pc : '0;
    assign pc_plus4_o = id_valid_o ? (head_c.pc + 32'(INSTR_BYTES)) : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned_o = misaligned_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order instruction memory model
// whose response word is addr ^ 32'hDEAD_0000 and whose latency is adjustable.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    lat  = 1;
    int    ncyc = 0;

    fetch_stage #(
        .RESET_PC        (32'h0000_0100),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    // Memory model: grants seen at the falling edge are taken at the next
    // rising edge; the response is presented lat cycles later.
    always @(negedge clk) begin
        ncyc++;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (rst) begin
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due <= ncyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend[0].addr ^ 32'hDEAD_0000;
                void'(pend.pop_front());
            end
            if (imem_req_o && imem_gnt_i) pend.push_back('{addr: imem_addr_o, due: ncyc + lat});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Advance until the next valid head (bounded) and check its contents.
    task automatic expect_head(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
        for (int n = 0; n < 20; n++) begin
            step();
            if (id_valid_o) break;
        end
        check1({tag, " valid"}, id_valid_o, 1'b1);
        check32({tag, " pc"}, pc_o, epc);
        check32({tag, " instr"}, instr_o, einstr);
        check32({tag, " pc_plus4"}, pc_plus4_o, epc + 32'd4);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        check1("rst req", imem_req_o, 1'b0);
        check1("rst valid", id_valid_o, 1'b0);
        check32("rst instr", instr_o, 32'h0);
        check32("rst pc", pc_o, 32'h0);
        check32("rst pc_plus4", pc_plus4_o, 32'h0);
        check1("rst misaligned", misaligned_o, 1'b0);

        // Zero-wait streaming from RESET_PC
        rst = 1'b0;
        #1;
        check1("c0 req", imem_req_o, 1'b1);
        check32("c0 addr", imem_addr_o, 32'h0000_0100);
        step();
        check1("c1 req", imem_req_o, 1'b1);
        check32("c1 addr", imem_addr_o, 32'h0000_0104);
        check1("c1 valid", id_valid_o, 1'b0);
        step();
        check1("c2 valid", id_valid_o, 1'b1);
        check32("c2 pc", pc_o, 32'h0000_0100);
        check32("c2 instr", instr_o, 32'hDEAD_0100);
        check32("c2 pc_plus4", pc_plus4_o, 32'h0000_0104);
        check1("c2 req credit", imem_req_o, 1'b0);
        expect_head("s104", 32'h0000_0104, 32'hDEAD_0104);
        expect_head("s108", 32'h0000_0108, 32'hDEAD_0108);

        // Decode stall: head holds, requests stop once credits are used
        id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check1("stall valid", id_valid_o, 1'b1);
            check32("stall pc", pc_o, 32'h0000_0108);
            check32("stall instr", instr_o, 32'hDEAD_0108);
        end
        check1("stall req", imem_req_o, 1'b0);
        id_ready_i = 1'b1;
        expect_head("r10c", 32'h0000_010C, 32'hDEAD_010C);
        expect_head("r110", 32'h0000_0110, 32'hDEAD_0110);

        // Latency 3, two outstanding, back-to-back redirects ending at 0x200
        lat = 3;
        reset_dut();
        step();
        step();
        check1("l3 req full", imem_req_o, 1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0180;
        #1;
        check1("redir req", imem_req_o, 1'b0);
        step();
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        #1;
        check1("l3 req tgt", imem_req_o, 1'b1);
        check32("l3 addr tgt", imem_addr_o, 32'h0000_0200);
        expect_head("l3 h200", 32'h0000_0200, 32'hDEAD_0200);
        expect_head("l3 h204", 32'h0000_0204, 32'hDEAD_0204);

        // Redirect coinciding with rvalid and pop
        lat = 1;
        reset_dut();
        step();
        step();
        check32("rp head", pc_o, 32'h0000_0100);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        #1;
        check1("rp req", imem_req_o, 1'b0);
        step();
        redirect_i = 1'b0;
        #1;
        check1("rp empty", id_valid_o, 1'b0);
        check1("rp req tgt", imem_req_o, 1'b1);
        check32("rp addr tgt", imem_addr_o, 32'h0000_0300);
        expect_head("rp h300", 32'h0000_0300, 32'hDEAD_0300);

        // PC wrap at the top of the address space
        reset_dut();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1;
        check1("wr req", imem_req_o, 1'b0);
        step();
        redirect_i = 1'b0;
        #1;
        check1("wr req top", imem_req_o, 1'b1);
        check32("wr addr top", imem_addr_o, 32'hFFFF_FFFC);
        step();
        check1("wr req zero", imem_req_o, 1'b1);
        check32("wr addr zero", imem_addr_o, 32'h0000_0000);
        expect_head("wr htop", 32'hFFFF_FFFC, 32'h2152_FFFC);
        expect_head("wr h0", 32'h0000_0000, 32'hDEAD_0000);

        // Misaligned redirect target
        reset_dut();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0202;
        step();
        redirect_i = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            check1("ma flag", misaligned_o, 1'b1);
            check1("ma req", imem_req_o, 1'b0);
            check1("ma valid", id_valid_o, 1'b0);
            step();
        end
        reset_dut();
        check1("ma flag cleared", misaligned_o, 1'b0);
        check32("ma addr reset", imem_addr_o, 32'h0000_0100);
`else
        check1("ma flag", misaligned_o, 1'b0);
        check1("ma req", imem_req_o, 1'b1);
        check32("ma addr", imem_addr_o, 32'h0000_0200);
        expect_head("ma h200", 32'h0000_0200, 32'hDEAD_0200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
